// File: rtl/mem_arbiter.sv
// Two-client (instruction/data) arbiter onto a single line-wide memory port.
// Alternating priority on ties; address, write data and operation are latched at grant.
module mem_arbiter (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_read,
  input  logic [15:0]  i_addr,
  output logic [127:0] i_rdata,
  output logic         i_resp,
  input  logic         d_read,
  input  logic         d_write,
  input  logic [15:0]  d_addr,
  input  logic [127:0] d_wdata,
  output logic [127:0] d_rdata,
  output logic         d_resp,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [15:0]  pmem_addr,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp
);

  typedef enum logic [1:0] {StIdle, StGrantI, StGrantD, StResp} state_e;

  state_e         state_q, state_d;
  // 1 = data side; it also names the owner of the transaction in flight
  logic           last_grant_q, last_grant_d;
  logic           op_write_q, op_write_d;
  logic [15:0]    addr_q, addr_d;
  logic [127:0]   wdata_q, wdata_d;
  logic [127:0]   i_rdata_q, i_rdata_d;
  logic [127:0]   d_rdata_q, d_rdata_d;

  logic           d_req;
  logic           d_wins;

  always_comb begin
    d_req  = d_read | d_write;
    // On a tie the side that did not win last time goes first
    d_wins = d_req & (~i_read | ~last_grant_q);
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_write_d   = op_write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;

    unique case (state_q)
      StIdle: begin
        if (i_read | d_req) begin
          state_d      = d_wins ? StGrantD : StGrantI;
          last_grant_d = d_wins;
          addr_d       = d_wins ? d_addr : i_addr;
          wdata_d      = d_wdata;
          op_write_d   = d_wins & d_write;
        end
      end
      StGrantI: begin
        if (pmem_resp) begin
          state_d   = StResp;
          i_rdata_d = pmem_rdata;
        end
      end
      StGrantD: begin
        if (pmem_resp) begin
          state_d = StResp;
          if (!op_write_q) begin
            d_rdata_d = pmem_rdata;
          end
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b0;
      op_write_q   <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_write_q   <= op_write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  // Outputs decode only registered state, so reset clears them without waiting for clk
  always_comb begin
    pmem_read  = ((state_q == StGrantI) || (state_q == StGrantD)) && !op_write_q;
    pmem_write = ((state_q == StGrantI) || (state_q == StGrantD)) && op_write_q;
    pmem_addr  = addr_q;
    pmem_wdata = wdata_q;
    i_resp     = (state_q == StResp) && !last_grant_q;
    d_resp     = (state_q == StResp) && last_grant_q;
    i_rdata    = i_rdata_q;
    d_rdata    = d_rdata_q;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset; ports are listed below.
REQ-002 SHALL have port clk, input, 1 bit: system clock; all state updates on the rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port i_read, input, 1 bit: instruction-side line read request.
REQ-005 SHALL have port i_addr, input, 16 bits: instruction-side line address.
REQ-006 SHALL have port i_rdata, output, 128 bits: instruction-side returned line.
REQ-007 SHALL have port i_resp, output, 1 bit: instruction-side completion pulse.
REQ-008 SHALL have port d_read, input, 1 bit: data-side line read request.
REQ-009 SHALL have port d_write, input, 1 bit: data-side line write request.
REQ-010 SHALL have port d_addr, input, 16 bits: data-side line address.
REQ-011 SHALL have port d_wdata, input, 128 bits: data-side write line.
REQ-012 SHALL have port d_rdata, output, 128 bits: data-side returned line.
REQ-013 SHALL have port d_resp, output, 1 bit: data-side completion pulse.
REQ-014 SHALL have port pmem_read, output, 1 bit: shared-memory read strobe.
REQ-015 SHALL have port pmem_write, output, 1 bit: shared-memory write strobe.
REQ-016 SHALL have port pmem_addr, output, 16 bits: shared-memory line address.
REQ-017 SHALL have port pmem_wdata, output, 128 bits: shared-memory write line.
REQ-018 SHALL have port pmem_rdata, input, 128 bits: shared-memory read line.
REQ-019 SHALL have port pmem_resp, input, 1 bit: shared-memory completion, high for one cycle.

Function
REQ-020 SHALL implement an FSM with states IDLE, GRANT_I, GRANT_D and RESP.
REQ-021 SHALL sample requests only in IDLE; a request arriving in any other state waits until IDLE.
REQ-022 SHALL keep a last_grant register (I or D).
- Tie rule: when i_read and (d_read or d_write) are both high in IDLE, the side not equal to last_grant wins.
- last_grant resets to I, so D wins the first tie.
REQ-023 SHALL, on a grant, perform all of the following at the same edge:
- latch the winner's address into an address register;
- latch d_wdata into a data register;
- latch the operation into an operation register (write if d_write, else read);
- update last_grant.
REQ-024 SHALL, if d_read and d_write are both high, treat the request as a write.
REQ-025 SHALL drive pmem_addr and pmem_wdata only from the latched registers; input changes after the grant SHALL NOT affect them.
REQ-026 SHALL, in GRANT_I or GRANT_D, hold pmem_read or pmem_write high continuously until pmem_resp.
- Only one of pmem_read and pmem_write SHALL be high, per the latched operation.
- Both SHALL be 0 in IDLE and RESP.
REQ-027 SHALL, on pmem_resp in a grant state, capture pmem_rdata into the winner's rdata register and move to RESP.
- For writes, d_rdata SHALL be left unchanged.
REQ-028 SHALL, in RESP, assert the winner's resp (i_resp or d_resp) for exactly one cycle, then return to IDLE.
REQ-029 SHALL hold i_rdata and d_rdata stable between responses.
REQ-030 SHALL give a latency of one cycle from request to strobe, and one cycle from pmem_resp to client resp.
- Request high at edge N gives a strobe in cycle N+1.
- pmem_resp at edge K gives client resp in cycle K+1 and IDLE at K+2.
REQ-031 SHALL ignore pmem_resp in IDLE and RESP.
REQ-032 SHALL never assert i_resp and d_resp in the same cycle.
REQ-033 SHALL never assert a resp to a side that was not granted.

Reset
REQ-034 SHALL, while reset is high, immediately force the following, independent of clk:
- state = IDLE and last_grant = I;
- pmem_read, pmem_write, i_resp and d_resp = 0;
- pmem_addr, pmem_wdata, i_rdata and d_rdata = 0.
REQ-035 SHALL, on reset during a grant or RESP, abandon the transaction with no resp issued; the first edge after reset deasserts resumes in IDLE.

Verification
REQ-036 SHALL cover a lone I read:
- stimulus: i_read=1, i_addr=0x1230; pmem_resp after 3 cycles with pmem_rdata=0xA5..A5;
- response: pmem_read=1 and pmem_addr=0x1230 for 3 cycles; then i_resp=1 for one cycle with i_rdata=0xA5..A5; d_resp stays 0.
REQ-037 SHALL cover a tie after reset:
- stimulus: i_read=1, d_read=1, d_addr=0x4000;
- response: D is served first (pmem_addr=0x4000, d_resp), then I is served with no intervening idle request cycle beyond RESP→IDLE.
REQ-038 SHALL cover alternation:
- stimulus: i_read and d_write held high continuously for 4 transactions;
- response: grant order D, I, D, I; pmem_write high only during D grants.
REQ-039 SHALL cover latching:
- stimulus: d_write with d_addr=0x0100, d_wdata=X; change d_addr to 0xFFFF one cycle after the grant;
- response: pmem_addr stays 0x0100 and pmem_wdata stays X until pmem_resp.
REQ-040 SHALL cover reset mid-grant:
- stimulus: assert reset in GRANT_I before pmem_resp;
- response: pmem_read=0 immediately, no i_resp; after release with i_read=1, a fresh grant occurs one cycle later.
REQ-041 SHALL cover stray responses:
- stimulus: pmem_resp=1 while in IDLE with no request;
- response: no state change and no resp.
